// File: rtl/keystone_touch_mapper.sv
// Keystone touch mapper: removes projection skew from camera hits,
// resolves them to white keys / angle buttons and debounces per frame.
module keystone_touch_mapper #(
    parameter int WHITE_KEY_WIDTH = 90,
    parameter int PIANO_LEFT      = 42,
    parameter int NUM_KEYS        = 10,
    parameter int PIANO_MIDDLE    = 492,
    parameter int KEY_TOP         = 192,
    parameter int BASE_ROW        = 496,
    parameter int BUTTON_TOP      = 96,
    parameter int PRESS_FRAMES    = 2,
    parameter int RELEASE_FRAMES  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hit_valid,
    input  logic [10:0] hit_x,
    input  logic [9:0]  hit_y,
    output logic        hit_ready,
    input  logic        frame_tick,
    output logic [16:0] key_num,
    output logic        note_ready
);

    localparam int CMAX = (PRESS_FRAMES > RELEASE_FRAMES) ?
                          PRESS_FRAMES : RELEASE_FRAMES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [16:0] BIT_DOWN = 17'(1) << 14;
    localparam logic [16:0] BIT_UP   = 17'(1) << 15;
    localparam logic [16:0] IMPL     = BIT_DOWN | BIT_UP |
                                       ((17'(1) << NUM_KEYS) - 17'(1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNWARP,
        S_DIVIDE,
        S_RESOLVE
    } state_t;

    state_t state_q, state_d;

    logic [10:0] x_q;
    logic [9:0]  y_q;
    logic [11:0] rem_q;
    logic [3:0]  k_q;
    logic [16:0] cand_q;
    logic [16:0] fm_q;

    logic [9:0]  dy;
    logic [6:0]  d;
    logic [11:0] px;
    logic        left_half;
    logic        in_keys;
    logic        in_btn;
    logic        rem_bad;
    logic        rem_last;

    logic [16:0] hit_now;
    logic [16:0] key_d;
    logic [CW-1:0] pc_q [17];
    logic [CW-1:0] rc_q [17];
    logic [CW-1:0] pc_d [17];
    logic [CW-1:0] rc_d [17];

    // Unwarp arithmetic and row/remainder classification
    always_comb begin
        dy        = 10'(BASE_ROW) - y_q;
        d         = 7'(({2'b00, dy} * 12'd3) >> 3);
        left_half = x_q < 11'(PIANO_MIDDLE);
        px        = left_half ? ({1'b0, x_q} + {5'b0, d})
                              : ({1'b0, x_q} - {5'b0, d});
        in_keys   = (y_q >= 10'(KEY_TOP)) && (y_q < 10'(BASE_ROW));
        in_btn    = (y_q >= 10'(BUTTON_TOP)) && (y_q < 10'(KEY_TOP));
        rem_bad   = rem_q[11] ||
                    (rem_q >= 12'(NUM_KEYS * WHITE_KEY_WIDTH));
        rem_last  = rem_q < 12'(WHITE_KEY_WIDTH);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and handshake output
    always_comb begin
        state_d   = state_q;
        hit_ready = (state_q == S_IDLE);
        unique case (state_q)
            S_IDLE:    if (hit_valid) state_d = S_UNWARP;
            S_UNWARP:  state_d = in_keys ? S_DIVIDE : S_RESOLVE;
            S_DIVIDE:  if (rem_bad || rem_last) state_d = S_RESOLVE;
            S_RESOLVE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Hit datapath: latch, unwarp, repeated-subtract key divide
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q    <= '0;
            y_q    <= '0;
            rem_q  <= '0;
            k_q    <= '0;
            cand_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (hit_valid) begin
                        x_q <= hit_x;
                        y_q <= hit_y;
                    end
                end
                S_UNWARP: begin
                    k_q   <= '0;
                    rem_q <= px - 12'(PIANO_LEFT);
                    if (in_btn)
                        cand_q <= left_half ? BIT_DOWN : BIT_UP;
                    else
                        cand_q <= '0;
                end
                S_DIVIDE: begin
                    if (!rem_bad) begin
                        if (rem_last) begin
                            cand_q <= 17'(1) << k_q;
                        end else begin
                            rem_q <= rem_q - 12'(WHITE_KEY_WIDTH);
                            k_q   <= k_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-bit debounce counters evaluated against this frame's hits
    always_comb begin
        hit_now = fm_q | ((state_q == S_RESOLVE) ? cand_q : '0);
        key_d   = key_num;
        for (int b = 0; b < 17; b++) begin
            pc_d[b] = pc_q[b];
            rc_d[b] = rc_q[b];
            if (IMPL[b]) begin
                if (hit_now[b]) begin
                    rc_d[b] = '0;
                    if (pc_q[b] != CW'(PRESS_FRAMES))
                        pc_d[b] = pc_q[b] + CW'(1);
                    if (pc_d[b] == CW'(PRESS_FRAMES))
                        key_d[b] = 1'b1;
                end else begin
                    pc_d[b] = '0;
                    if (rc_q[b] != CW'(RELEASE_FRAMES))
                        rc_d[b] = rc_q[b] + CW'(1);
                    if (rc_d[b] == CW'(RELEASE_FRAMES))
                        key_d[b] = 1'b0;
                end
            end else begin
                key_d[b] = 1'b0;
            end
        end
    end

    // Frame mask accumulation and frame-boundary key update
    always_ff @(posedge clk) begin
        if (!reset) begin
            fm_q       <= '0;
            key_num    <= '0;
            note_ready <= 1'b0;
            for (int b = 0; b < 17; b++) begin
                pc_q[b] <= '0;
                rc_q[b] <= '0;
            end
        end else if (frame_tick) begin
            fm_q       <= '0;
            key_num    <= key_d;
            note_ready <= |(key_d & ~key_num);
            for (int b = 0; b < 17; b++) begin
                pc_q[b] <= pc_d[b];
                rc_q[b] <= rc_d[b];
            end
        end else begin
            note_ready <= 1'b0;
            if (state_q == S_RESOLVE)
                fm_q <= fm_q | cand_q;
        end
    end

endmodule

// File: tb/tb_keystone_touch_mapper.sv
// Directed testbench for keystone_touch_mapper.
// Hand-computed key/button expectations per scenario.
module tb_keystone_touch_mapper;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hit_valid = 1'b0;
    logic [10:0] hit_x = '0;
    logic [9:0]  hit_y = '0;
    logic        frame_tick = 1'b0;
    logic        hit_ready;
    logic [16:0] key_num;
    logic        note_ready;

    int checks = 0;
    int passed = 0;
    int note_cnt = 0;

    keystone_touch_mapper dut (
        .clk        (clk),
        .reset      (reset),
        .hit_valid  (hit_valid),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .hit_ready  (hit_ready),
        .frame_tick (frame_tick),
        .key_num    (key_num),
        .note_ready (note_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (note_ready === 1'b1) note_cnt++;

    task automatic reset_dut();
        reset      = 1'b0;
        hit_valid  = 1'b0;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_hit(input int x, input int y, output int low);
        int n;
        n = 0;
        while (hit_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        hit_valid = 1'b1;
        hit_x     = 11'(x);
        hit_y     = 10'(y);
        @(posedge clk); #1;
        hit_valid = 1'b0;
        low = 0;
        while (hit_ready !== 1'b1 && low < 20) begin
            @(posedge clk); #1; low++;
        end
        checks++;
        if (n >= 20 || low >= 20)
            $display("FAIL hit_timeout: wait_in=%0d busy=%0d limit 20", n, low);
        else
            passed++;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        hit_valid  = 1'b0;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hit_ready !== 1'b1)
            $display("FAIL rst_ready: got %b expected 1", hit_ready);
        else passed++;
        checks++;
        if (key_num !== 17'h0)
            $display("FAIL rst_key: got %h expected 00000", key_num);
        else passed++;
        checks++;
        if (note_ready !== 1'b0)
            $display("FAIL rst_note: got %b expected 0", note_ready);
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_key5_and_release();
        int low, base;
        reset_dut();
        base = note_cnt;
        send_hit(492, 495, low); tick();
        checks++;
        if (key_num !== 17'h0)
            $display("FAIL k5_f1: got %h expected 00000", key_num);
        else passed++;
        send_hit(492, 495, low); tick();
        checks++;
        if (key_num !== 17'h00020)
            $display("FAIL k5_f2: got %h expected 00020", key_num);
        else passed++;
        checks++;
        if (note_cnt - base !== 1)
            $display("FAIL k5_pulse: got %0d expected 1", note_cnt - base);
        else passed++;
        send_hit(492, 495, low);
        send_hit(492, 495, low); tick();
        checks++;
        if (key_num !== 17'h00020 || note_cnt - base !== 1)
            $display("FAIL k5_f3: key %h pulses %0d expected 00020 1",
                     key_num, note_cnt - base);
        else passed++;
        tick(); tick();
        checks++;
        if (key_num !== 17'h00020)
            $display("FAIL rel_2: got %h expected 00020", key_num);
        else passed++;
        tick();
        checks++;
        if (key_num !== 17'h0)
            $display("FAIL rel_3: got %h expected 00000", key_num);
        else passed++;
        checks++;
        if (note_cnt - base !== 1)
            $display("FAIL rel_pulse: got %0d expected 1", note_cnt - base);
        else passed++;
    endtask

    task automatic test_key1();
        int low, base;
        reset_dut();
        base = note_cnt;
        repeat (2) begin
            send_hit(100, 192, low); tick();
        end
        checks++;
        if (key_num !== 17'h00002 || note_cnt - base !== 1)
            $display("FAIL k1: key %h pulses %0d expected 00002 1",
                     key_num, note_cnt - base);
        else passed++;
    endtask

    task automatic test_key8();
        int low, worst;
        reset_dut();
        worst = 0;
        repeat (2) begin
            send_hit(900, 300, low);
            if (low > worst) worst = low;
            tick();
        end
        checks++;
        if (key_num !== 17'h00100)
            $display("FAIL k8: got %h expected 00100", key_num);
        else passed++;
        checks++;
        if (worst < 1 || worst > 11)
            $display("FAIL k8_busy: got %0d expected 1..11", worst);
        else passed++;
    endtask

    task automatic test_out_of_range();
        int low, base;
        reset_dut();
        base = note_cnt;
        repeat (3) begin
            send_hit(20, 495, low);
            send_hit(500, 600, low);
            send_hit(500, 50, low);
            tick();
        end
        checks++;
        if (key_num !== 17'h0)
            $display("FAIL oor_key: got %h expected 00000", key_num);
        else passed++;
        checks++;
        if (note_cnt - base !== 0)
            $display("FAIL oor_note: got %0d expected 0", note_cnt - base);
        else passed++;
    endtask

    task automatic test_buttons();
        int low, base;
        reset_dut();
        base = note_cnt;
        repeat (2) begin
            send_hit(600, 150, low); tick();
        end
        checks++;
        if (key_num !== 17'h08000 || note_cnt - base !== 1)
            $display("FAIL btn_up: key %h pulses %0d expected 08000 1",
                     key_num, note_cnt - base);
        else passed++;
        repeat (2) begin
            send_hit(300, 150, low); tick();
        end
        checks++;
        if (key_num !== 17'h0C000 || note_cnt - base !== 2)
            $display("FAIL btn_down: key %h pulses %0d expected 0C000 2",
                     key_num, note_cnt - base);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int low, n, base;
        reset_dut();
        n = 0;
        while (hit_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        hit_valid = 1'b1;
        hit_x     = 11'd900;
        hit_y     = 10'd300;
        @(posedge clk); #1;
        hit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (hit_ready !== 1'b1 || key_num !== 17'h0)
            $display("FAIL mid_rst: ready %b key %h expected 1 00000",
                     hit_ready, key_num);
        else passed++;
        reset = 1'b1;
        base = note_cnt;
        tick();
        send_hit(900, 300, low); tick();
        checks++;
        if (key_num !== 17'h0)
            $display("FAIL mid_discard: got %h expected 00000", key_num);
        else passed++;
        send_hit(900, 300, low); tick();
        checks++;
        if (key_num !== 17'h00100 || note_cnt - base !== 1)
            $display("FAIL mid_after: key %h pulses %0d expected 00100 1",
                     key_num, note_cnt - base);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_key5_and_release();
        test_key1();
        test_key8();
        test_out_of_range();
        test_buttons();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
